y86_hazard_decode_execute: RTL and testbench



---
 rtl/y86_hazard_decode_execute.sv | 262 ++++++++++++++++++++++++++
 tb/tb_y86_hazard_decode_execute.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/y86_hazard_decode_execute.sv
// Y86-64 decode/execute slice: register file, forwarding, E and M pipeline
// registers, ALU, condition codes and the pipeline hazard control.
module y86_hazard_decode_execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:3]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [0:3]  m_stat,
  input  logic [63:0] m_valM,
  input  logic [0:3]  W_stat,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        W_stall,
  output logic [0:3]  M_stat,
  output logic [3:0]  M_icode,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM,
  output logic        M_cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [63:0] reg0,  output logic [63:0] reg1,  output logic [63:0] reg2,
  output logic [63:0] reg3,  output logic [63:0] reg4,  output logic [63:0] reg5,
  output logic [63:0] reg6,  output logic [63:0] reg7,  output logic [63:0] reg8,
  output logic [63:0] reg9,  output logic [63:0] reg10, output logic [63:0] reg11,
  output logic [63:0] reg12, output logic [63:0] reg13, output logic [63:0] reg14
);
  localparam int unsigned XW   = 64;
  localparam int unsigned RW   = 4;
  localparam int unsigned NREG = 15;

  localparam logic [RW-1:0] RNONE    = 4'hF;
  localparam logic [RW-1:0] RSP      = 4'h4;
  localparam logic [0:3]    S_AOK    = 4'b1000;
  localparam logic [RW-1:0] I_NOP    = 4'h1;
  localparam logic [RW-1:0] I_RRMOVQ = 4'h2;
  localparam logic [RW-1:0] I_IRMOVQ = 4'h3;
  localparam logic [RW-1:0] I_RMMOVQ = 4'h4;
  localparam logic [RW-1:0] I_MRMOVQ = 4'h5;
  localparam logic [RW-1:0] I_OPQ    = 4'h6;
  localparam logic [RW-1:0] I_JXX    = 4'h7;
  localparam logic [RW-1:0] I_CALL   = 4'h8;
  localparam logic [RW-1:0] I_RET    = 4'h9;
  localparam logic [RW-1:0] I_PUSHQ  = 4'hA;
  localparam logic [RW-1:0] I_POPQ   = 4'hB;
  localparam logic [XW-1:0] EIGHT    = 64'd8;

  typedef struct packed {
    logic [0:3]    stat;
    logic [RW-1:0] icode;
    logic [RW-1:0] ifun;
    logic [XW-1:0] valc;
    logic [XW-1:0] vala;
    logic [XW-1:0] valb;
    logic [RW-1:0] dste;
    logic [RW-1:0] dstm;
  } e_reg_t;

  typedef struct packed {
    logic [0:3]    stat;
    logic [RW-1:0] icode;
    logic          cnd;
    logic [XW-1:0] vale;
    logic [XW-1:0] vala;
    logic [RW-1:0] dste;
    logic [RW-1:0] dstm;
  } m_reg_t;

  localparam e_reg_t E_BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: '0, valc: '0,
                                  vala: '0, valb: '0, dste: RNONE, dstm: RNONE};
  localparam m_reg_t M_BUBBLE = '{stat: S_AOK, icode: I_NOP, cnd: 1'b0, vale: '0,
                                  vala: '0, dste: RNONE, dstm: RNONE};

  e_reg_t        e_q, e_d;
  m_reg_t        m_q, m_d;
  logic [XW-1:0] rf_q [NREG];
  logic          zf_q, sf_q, of_q;

  logic [RW-1:0] d_srca, d_srcb, d_dste, d_dstm;
  logic [XW-1:0] d_vala, d_valb;
  logic [XW-1:0] alu_a, alu_b, e_vale;
  logic [RW-1:0] alu_fn, e_dste;
  logic          alu_of, e_cnd, sfo;
  logic          loaduse, retp, mispred, m_bubble, set_cc;
  logic          w_icode_unused;

  assign w_icode_unused = ^W_icode;

  // Source/destination register selection
  always_comb begin
    d_srca = RNONE;
    d_srcb = RNONE;
    d_dste = RNONE;
    d_dstm = RNONE;
    case (D_icode)
      I_RRMOVQ: begin d_srca = D_rA; d_dste = D_rB; end
      I_IRMOVQ: d_dste = D_rB;
      I_RMMOVQ: begin d_srca = D_rA; d_srcb = D_rB; end
      I_MRMOVQ: begin d_srcb = D_rB; d_dstm = D_rA; end
      I_OPQ:    begin d_srca = D_rA; d_srcb = D_rB; d_dste = D_rB; end
      I_CALL:   begin d_srcb = RSP; d_dste = RSP; end
      I_RET:    begin d_srca = RSP; d_srcb = RSP; d_dste = RSP; end
      I_PUSHQ:  begin d_srca = D_rA; d_srcb = RSP; d_dste = RSP; end
      I_POPQ:   begin d_srca = RSP; d_srcb = RSP; d_dste = RSP; d_dstm = D_rA; end
      default:  ;
    endcase
  end

  // Operand forwarding, youngest producer first
  always_comb begin
    d_vala = '0;
    d_valb = '0;
    if (D_icode == I_JXX || D_icode == I_CALL) d_vala = D_valP;
    else if (d_srca == RNONE)                  d_vala = '0;
    else if (d_srca == e_dste)                 d_vala = e_vale;
    else if (d_srca == m_q.dstm)               d_vala = m_valM;
    else if (d_srca == m_q.dste)               d_vala = m_q.vale;
    else if (d_srca == W_dstM)                 d_vala = W_valM;
    else if (d_srca == W_dstE)                 d_vala = W_valE;
    else                                       d_vala = rf_q[d_srca];

    if (d_srcb == RNONE)                       d_valb = '0;
    else if (d_srcb == e_dste)                 d_valb = e_vale;
    else if (d_srcb == m_q.dstm)               d_valb = m_valM;
    else if (d_srcb == m_q.dste)               d_valb = m_q.vale;
    else if (d_srcb == W_dstM)                 d_valb = W_valM;
    else if (d_srcb == W_dstE)                 d_valb = W_valE;
    else                                       d_valb = rf_q[d_srcb];
  end

  // ALU operand select and evaluation
  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (e_q.icode)
      I_RRMOVQ, I_OPQ:                alu_a = e_q.vala;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:   alu_a = e_q.valc;
      I_CALL, I_PUSHQ:                alu_a = -EIGHT;
      I_RET, I_POPQ:                  alu_a = EIGHT;
      default:                        alu_a = '0;
    endcase
    case (e_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = e_q.valb;
      default:                                                   alu_b = '0;
    endcase
    alu_fn = (e_q.icode == I_OPQ) ? e_q.ifun : 4'h0;
    case (alu_fn)
      4'h1: begin
        e_vale = alu_b - alu_a;
        alu_of = (alu_a[XW-1] != alu_b[XW-1]) && (e_vale[XW-1] != alu_b[XW-1]);
      end
      4'h2:    begin e_vale = alu_a & alu_b; alu_of = 1'b0; end
      4'h3:    begin e_vale = alu_a ^ alu_b; alu_of = 1'b0; end
      default: begin
        e_vale = alu_b + alu_a;
        alu_of = (alu_a[XW-1] == alu_b[XW-1]) && (e_vale[XW-1] != alu_a[XW-1]);
      end
    endcase
  end

  // Branch / conditional-move condition from the stored flags
  always_comb begin
    sfo = sf_q ^ of_q;
    case (e_q.ifun)
      4'h0:    e_cnd = 1'b1;
      4'h1:    e_cnd = sfo | zf_q;
      4'h2:    e_cnd = sfo;
      4'h3:    e_cnd = zf_q;
      4'h4:    e_cnd = ~zf_q;
      4'h5:    e_cnd = ~sfo;
      4'h6:    e_cnd = ~sfo & ~zf_q;
      default: e_cnd = 1'b0;
    endcase
    e_dste = (e_q.icode == I_RRMOVQ && !e_cnd) ? RNONE : e_q.dste;
  end

  // Hazard control
  always_comb begin
    loaduse  = (e_q.icode == I_MRMOVQ || e_q.icode == I_POPQ) && (e_q.dstm != RNONE) &&
               (e_q.dstm == d_srca || e_q.dstm == d_srcb);
    retp     = (D_icode == I_RET) || (e_q.icode == I_RET) || (m_q.icode == I_RET);
    mispred  = (e_q.icode == I_JXX) && !e_cnd;
    m_bubble = (m_stat != S_AOK) || (W_stat != S_AOK);
    set_cc   = (e_q.icode == I_OPQ) && (m_stat == S_AOK) && (W_stat == S_AOK);
  end

  assign F_stall  = loaduse | retp;
  assign D_stall  = loaduse;
  assign D_bubble = mispred | (!loaduse & retp);
  assign E_bubble = mispred | loaduse;
  assign W_stall  = (W_stat != S_AOK);

  // Next-state for E and M pipeline registers
  always_comb begin
    e_d = E_BUBBLE;
    m_d = M_BUBBLE;
    if (!E_bubble)
      e_d = '{stat: D_stat, icode: D_icode, ifun: D_ifun, valc: D_valC,
              vala: d_vala, valb: d_valb, dste: d_dste, dstm: d_dstm};
    if (!m_bubble)
      m_d = '{stat: e_q.stat, icode: e_q.icode, cnd: e_cnd, vale: e_vale,
              vala: e_q.vala, dste: e_dste, dstm: e_q.dstm};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q  <= E_BUBBLE;
      m_q  <= M_BUBBLE;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      of_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      if (set_cc) begin
        zf_q <= (e_vale == '0);
        sf_q <= e_vale[XW-1];
        of_q <= alu_of;
      end
      // dstM write is issued last so it wins a collision with dstE
      if (W_dstE != RNONE) rf_q[W_dstE] <= W_valE;
      if (W_dstM != RNONE) rf_q[W_dstM] <= W_valM;
    end
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_dstE  = m_q.dste;
  assign M_dstM  = m_q.dstm;
  assign M_cnd   = m_q.cnd;
  assign M_valE  = m_q.vale;
  assign M_valA  = m_q.vala;

  assign reg0  = rf_q[0];
  assign reg1  = rf_q[1];
  assign reg2  = rf_q[2];
  assign reg3  = rf_q[3];
  assign reg4  = rf_q[4];
  assign reg5  = rf_q[5];
  assign reg6  = rf_q[6];
  assign reg7  = rf_q[7];
  assign reg8  = rf_q[8];
  assign reg9  = rf_q[9];
  assign reg10 = rf_q[10];
  assign reg11 = rf_q[11];
  assign reg12 = rf_q[12];
  assign reg13 = rf_q[13];
  assign reg14 = rf_q[14];

endmodule

// File: tb/tb_y86_hazard_decode_execute.sv
// Bench for the Y86-64 decode/execute slice: directed hazard scenarios plus
// randomized traffic checked against an instruction-level pipeline model.
module tb_y86_hazard_decode_execute;
  localparam logic [0:3] AOK = 4'b1000;
  localparam logic [0:3] HLT = 4'b0100;
  localparam logic [0:3] ADR = 4'b0010;
  localparam logic [3:0] RN  = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:3]  D_stat, m_stat, W_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB, W_icode, W_dstE, W_dstM;
  logic [63:0] D_valC, D_valP, m_valM, W_valE, W_valM;
  logic        F_stall, D_stall, D_bubble, E_bubble, W_stall, M_cnd;
  logic [0:3]  M_stat;
  logic [3:0]  M_icode, M_dstE, M_dstM;
  logic [63:0] M_valE, M_valA;
  logic [63:0] rv [15];

  always #5 clk = ~clk;

  y86_hazard_decode_execute dut (
    .clk(clk), .rst_n(rst_n),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .m_stat(m_stat), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .W_stall(W_stall), .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE),
    .M_dstM(M_dstM), .M_cnd(M_cnd), .M_valE(M_valE), .M_valA(M_valA),
    .reg0(rv[0]), .reg1(rv[1]), .reg2(rv[2]), .reg3(rv[3]), .reg4(rv[4]),
    .reg5(rv[5]), .reg6(rv[6]), .reg7(rv[7]), .reg8(rv[8]), .reg9(rv[9]),
    .reg10(rv[10]), .reg11(rv[11]), .reg12(rv[12]), .reg13(rv[13]), .reg14(rv[14])
  );

  typedef struct {
    logic [0:3] stat; logic [3:0] icode, ifun;
    logic [63:0] valc, vala, valb; logic [3:0] dste, dstm;
  } es_t;
  typedef struct {
    logic [0:3] stat; logic [3:0] icode; logic cnd;
    logic [63:0] vale, vala; logic [3:0] dste, dstm;
  } ms_t;

  es_t         me, x_dec;
  ms_t         mm;
  logic        mz, ms, mo;
  logic [63:0] mr [15];
  logic        x_fstall, x_dstall, x_dbub, x_ebub, x_wstall, x_setcc, x_cnd, x_z, x_s, x_o;
  logic [63:0] x_vale;
  logic [3:0]  x_dste;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic model_reset();
    me = '{stat: AOK, icode: 4'h1, ifun: 4'h0, valc: 64'h0, vala: 64'h0, valb: 64'h0,
           dste: RN, dstm: RN};
    mm = '{stat: AOK, icode: 4'h1, cnd: 1'b0, vale: 64'h0, vala: 64'h0, dste: RN, dstm: RN};
    mz = 1'b1; ms = 1'b0; mo = 1'b0;
    for (int i = 0; i < 15; i++) mr[i] = 64'h0;
  endtask

  function automatic logic [63:0] fwd_val(input logic [3:0] src);
    if (src == RN)      return 64'h0;
    if (src == x_dste)  return x_vale;
    if (src == mm.dstm) return m_valM;
    if (src == mm.dste) return mm.vale;
    if (src == W_dstM)  return W_valM;
    if (src == W_dstE)  return W_valE;
    return mr[src];
  endfunction

  // Behavioural view of one cycle: what E computes and what decode produces
  task automatic model_eval();
    logic [63:0] a, b;
    logic signed [64:0] wide;
    logic [3:0] fn, sa, sb;
    logic lt, lu, retp, mis;
    a = 64'h0;
    if (me.icode inside {4'h2, 4'h6})             a = me.vala;
    else if (me.icode inside {4'h3, 4'h4, 4'h5})  a = me.valc;
    else if (me.icode inside {4'h8, 4'hA})        a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (me.icode inside {4'h9, 4'hB})        a = 64'd8;
    b  = (me.icode inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB}) ? me.valb : 64'h0;
    fn = (me.icode == 4'h6) ? me.ifun : 4'h0;
    if (fn == 4'h2)      begin x_vale = a & b; x_o = 1'b0; end
    else if (fn == 4'h3) begin x_vale = a ^ b; x_o = 1'b0; end
    else begin
      if (fn == 4'h1) wide = $signed({b[63], b}) - $signed({a[63], a});
      else            wide = $signed({b[63], b}) + $signed({a[63], a});
      x_vale = wide[63:0];
      x_o    = (wide[64] != wide[63]);
    end
    x_z = (x_vale == 64'h0);
    x_s = x_vale[63];
    lt  = ms ^ mo;
    case (me.ifun)
      4'h0: x_cnd = 1'b1;
      4'h1: x_cnd = lt | mz;
      4'h2: x_cnd = lt;
      4'h3: x_cnd = mz;
      4'h4: x_cnd = !mz;
      4'h5: x_cnd = !lt;
      4'h6: x_cnd = !lt && !mz;
      default: x_cnd = 1'b0;
    endcase
    x_dste = (me.icode == 4'h2 && !x_cnd) ? RN : me.dste;

    sa = RN; sb = RN;
    x_dec = '{stat: D_stat, icode: D_icode, ifun: D_ifun, valc: D_valC, vala: 64'h0,
              valb: 64'h0, dste: RN, dstm: RN};
    if (D_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) sa = D_rA;
    else if (D_icode inside {4'h9, 4'hB})        sa = 4'h4;
    if (D_icode inside {4'h4, 4'h5, 4'h6})       sb = D_rB;
    else if (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) sb = 4'h4;
    if (D_icode inside {4'h2, 4'h3, 4'h6})       x_dec.dste = D_rB;
    else if (D_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) x_dec.dste = 4'h4;
    if (D_icode inside {4'h5, 4'hB})             x_dec.dstm = D_rA;
    x_dec.vala = (D_icode inside {4'h7, 4'h8}) ? D_valP : fwd_val(sa);
    x_dec.valb = fwd_val(sb);

    lu   = (me.icode inside {4'h5, 4'hB}) && me.dstm != RN && (me.dstm == sa || me.dstm == sb);
    retp = (D_icode == 4'h9) || (me.icode == 4'h9) || (mm.icode == 4'h9);
    mis  = (me.icode == 4'h7) && !x_cnd;
    x_fstall = lu || retp;
    x_dstall = lu;
    x_dbub   = mis || (!lu && retp);
    x_ebub   = mis || lu;
    x_wstall = (W_stat != AOK);
    x_setcc  = (me.icode == 4'h6) && (m_stat == AOK) && (W_stat == AOK);
  endtask

  task automatic model_clock();
    if (m_stat != AOK || W_stat != AOK)
      mm = '{stat: AOK, icode: 4'h1, cnd: 1'b0, vale: 64'h0, vala: 64'h0, dste: RN, dstm: RN};
    else
      mm = '{stat: me.stat, icode: me.icode, cnd: x_cnd, vale: x_vale, vala: me.vala,
             dste: x_dste, dstm: me.dstm};
    if (x_ebub)
      me = '{stat: AOK, icode: 4'h1, ifun: 4'h0, valc: 64'h0, vala: 64'h0, valb: 64'h0,
             dste: RN, dstm: RN};
    else
      me = x_dec;
    if (x_setcc) begin mz = x_z; ms = x_s; mo = x_o; end
    if (W_dstE != RN) mr[W_dstE] = W_valE;
    if (W_dstM != RN) mr[W_dstM] = W_valM;
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_d(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [63:0] vc);
    D_stat = AOK; D_icode = ic; D_ifun = fn; D_rA = ra; D_rB = rb;
    D_valC = vc; D_valP = 64'h100;
  endtask

  task automatic set_idle();
    set_d(4'h1, 4'h0, RN, RN, 64'h0);
    m_stat = AOK; m_valM = 64'h0;
    W_stat = AOK; W_icode = 4'h1; W_dstE = RN; W_dstM = RN; W_valE = 64'h0; W_valM = 64'h0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    #1 model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    W_dstE = 4'h2; W_valE = 64'hABC;
    tick();
    n_chk++; if (rv[2] !== 64'hABC) begin n_fail++; $display("FAIL rf_write: got %h expected %h", rv[2], 64'hABC); end
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (M_icode !== 4'h1) begin n_fail++; $display("FAIL rst_M_icode: got %h expected 1", M_icode); end
    n_chk++; if (M_stat !== AOK) begin n_fail++; $display("FAIL rst_M_stat: got %b expected 1000", M_stat); end
    n_chk++; if (M_dstE !== RN || M_dstM !== RN) begin n_fail++; $display("FAIL rst_M_dst: got %h/%h expected f/f", M_dstE, M_dstM); end
    n_chk++; if (M_valE !== 64'h0 || M_valA !== 64'h0 || M_cnd !== 1'b0) begin n_fail++; $display("FAIL rst_M_vals: got %h/%h/%b expected 0", M_valE, M_valA, M_cnd); end
    for (int i = 0; i < 15; i++) begin
      n_chk++; if (rv[i] !== 64'h0) begin n_fail++; $display("FAIL rst_reg%0d: got %h expected 0", i, rv[i]); end
    end
    n_chk++; if (F_stall !== 1'b0 || E_bubble !== 1'b0) begin n_fail++; $display("FAIL rst_ctrl: got %b%b expected 00", F_stall, E_bubble); end
    model_reset();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    do_reset();
    set_d(4'h3, 4'h0, RN, 4'h0, 64'd10);
    tick();
    set_d(4'h6, 4'h0, 4'h0, 4'h0, 64'h0);
    tick();
    n_chk++; if (M_valE !== 64'd10 || M_icode !== 4'h3) begin n_fail++; $display("FAIL fwd_irmovq: got %h/%h expected 10/3", M_valE, M_icode); end
    set_d(4'h1, 4'h0, RN, RN, 64'h0);
    tick();
    n_chk++; if (M_valE !== 64'd20 || M_icode !== 4'h6) begin n_fail++; $display("FAIL fwd_add: got %h/%h expected 20/6", M_valE, M_icode); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(4'h5, 4'h0, 4'h2, RN, 64'h40);
    tick();
    set_d(4'h6, 4'h0, 4'h2, 4'h3, 64'h0);
    #1;
    n_chk++; if ({F_stall, D_stall, E_bubble, D_bubble} !== 4'b1110) begin n_fail++; $display("FAIL loaduse_ctrl: got %b%b%b%b expected 1110", F_stall, D_stall, E_bubble, D_bubble); end
    tick();
    n_chk++; if (M_icode !== 4'h5 || M_dstM !== 4'h2) begin n_fail++; $display("FAIL loaduse_M: got %h/%h expected 5/2", M_icode, M_dstM); end
    m_valM = 64'h1234;
    #1;
    n_chk++; if (F_stall !== 1'b0) begin n_fail++; $display("FAIL loaduse_release: got %b expected 0", F_stall); end
    tick();
    n_chk++; if (M_icode !== 4'h1) begin n_fail++; $display("FAIL loaduse_bubble: got %h expected 1", M_icode); end
    set_d(4'h1, 4'h0, RN, RN, 64'h0);
    tick();
    n_chk++; if (M_valE !== 64'h1234 || M_icode !== 4'h6) begin n_fail++; $display("FAIL loaduse_fwd: got %h/%h expected 1234/6", M_valE, M_icode); end
  endtask

  task automatic test_mispredict();
    do_reset();
    set_d(4'h3, 4'h0, RN, 4'h3, 64'd5);
    tick();
    set_d(4'h6, 4'h0, 4'h3, 4'h3, 64'h0);
    tick();
    set_d(4'h7, 4'h3, RN, RN, 64'h200);
    tick();
    set_d(4'h1, 4'h0, RN, RN, 64'h0);
    #1;
    n_chk++; if (D_bubble !== 1'b1 || E_bubble !== 1'b1) begin n_fail++; $display("FAIL mispred_ctrl: got %b%b expected 11", D_bubble, E_bubble); end
    tick();
    n_chk++; if (M_cnd !== 1'b0 || M_icode !== 4'h7) begin n_fail++; $display("FAIL mispred_M: got %b/%h expected 0/7", M_cnd, M_icode); end
  endtask

  task automatic test_overflow_cmov();
    do_reset();
    set_d(4'h3, 4'h0, RN, 4'h3, 64'h8000_0000_0000_0000);
    tick();
    set_d(4'h3, 4'h0, RN, 4'h1, 64'd1);
    tick();
    set_d(4'h6, 4'h1, 4'h1, 4'h3, 64'h0);
    tick();
    set_d(4'h2, 4'h1, 4'h1, 4'h5, 64'h0);
    tick();
    n_chk++; if (M_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ovf_sub: got %h expected 7fffffffffffffff", M_valE); end
    set_d(4'h2, 4'h6, 4'h1, 4'h6, 64'h0);
    tick();
    n_chk++; if (M_dstE !== 4'h5 || M_icode !== 4'h2 || M_valE !== 64'd1) begin n_fail++; $display("FAIL cmovle: got %h/%h/%h expected 5/2/1", M_dstE, M_icode, M_valE); end
    set_d(4'h1, 4'h0, RN, RN, 64'h0);
    tick();
    n_chk++; if (M_dstE !== RN || M_icode !== 4'h2) begin n_fail++; $display("FAIL cmovg: got %h/%h expected f/2", M_dstE, M_icode); end
  endtask

  task automatic test_ret_exception();
    do_reset();
    set_d(4'h9, 4'h0, RN, RN, 64'h0);
    for (int s = 0; s < 3; s++) begin
      #1;
      n_chk++; if (F_stall !== 1'b1 || D_bubble !== 1'b1) begin n_fail++; $display("FAIL ret_stage%0d: got %b%b expected 11", s, F_stall, D_bubble); end
      tick();
      set_d(4'h1, 4'h0, RN, RN, 64'h0);
    end
    #1;
    n_chk++; if (F_stall !== 1'b0 || D_bubble !== 1'b0) begin n_fail++; $display("FAIL ret_done: got %b%b expected 00", F_stall, D_bubble); end
    set_d(4'h3, 4'h0, RN, 4'h1, 64'd7);
    tick();
    set_d(4'h6, 4'h0, 4'h1, 4'h1, 64'h0);
    tick();
    set_d(4'h7, 4'h3, RN, RN, 64'h300);
    W_stat = HLT;
    #1;
    n_chk++; if (W_stall !== 1'b1) begin n_fail++; $display("FAIL exc_wstall: got %b expected 1", W_stall); end
    tick();
    n_chk++; if (M_icode !== 4'h1 || M_stat !== AOK) begin n_fail++; $display("FAIL exc_mbubble: got %h/%b expected 1/1000", M_icode, M_stat); end
    W_stat = AOK;
    set_d(4'h1, 4'h0, RN, RN, 64'h0);
    #1;
    n_chk++; if (D_bubble !== 1'b0 || E_bubble !== 1'b0 || W_stall !== 1'b0) begin n_fail++; $display("FAIL exc_no_setcc: got %b%b%b expected 000", D_bubble, E_bubble, W_stall); end
    tick();
  endtask

  function automatic logic [3:0] pick_reg();
    logic [3:0] r;
    r = 4'($urandom_range(0, 5));
    return (r == 4'd5) ? RN : r;
  endfunction

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1 model_reset();
        rst_n = 1'b1;
      end
      D_stat  = ($urandom_range(0, 15) == 0) ? ADR : AOK;
      D_icode = 4'($urandom_range(0, 11));
      if (D_icode == 4'h6)                          D_ifun = 4'($urandom_range(0, 3));
      else if (D_icode == 4'h2 || D_icode == 4'h7)  D_ifun = 4'($urandom_range(0, 15));
      else                                          D_ifun = 4'h0;
      D_rA = pick_reg(); D_rB = pick_reg();
      case ($urandom_range(0, 3))
        0:       D_valC = 64'h8000_0000_0000_0000;
        1:       D_valC = 64'hFFFF_FFFF_FFFF_FFFF;
        default: D_valC = {$urandom(), $urandom()};
      endcase
      D_valP  = {$urandom(), $urandom()};
      m_stat  = ($urandom_range(0, 15) == 0) ? ADR : AOK;
      m_valM  = {$urandom(), $urandom()};
      W_stat  = ($urandom_range(0, 15) == 0) ? HLT : AOK;
      W_icode = 4'($urandom_range(0, 11));
      W_dstE  = pick_reg(); W_dstM = pick_reg();
      W_valE  = {$urandom(), $urandom()};
      W_valM  = {$urandom(), $urandom()};
      model_eval();
      #1;
      n_chk++; if ({F_stall, D_stall, D_bubble, E_bubble, W_stall} !== {x_fstall, x_dstall, x_dbub, x_ebub, x_wstall}) begin
        n_fail++; $display("FAIL rnd_ctrl c%0d: got %b%b%b%b%b expected %b%b%b%b%b", c,
          F_stall, D_stall, D_bubble, E_bubble, W_stall, x_fstall, x_dstall, x_dbub, x_ebub, x_wstall);
      end
      tick();
      n_chk++; if (M_stat !== mm.stat || M_icode !== mm.icode || M_cnd !== mm.cnd) begin
        n_fail++; $display("FAIL rnd_M_hdr c%0d: got %b/%h/%b expected %b/%h/%b", c, M_stat, M_icode, M_cnd, mm.stat, mm.icode, mm.cnd);
      end
      n_chk++; if (M_dstE !== mm.dste || M_dstM !== mm.dstm) begin
        n_fail++; $display("FAIL rnd_M_dst c%0d: got %h/%h expected %h/%h", c, M_dstE, M_dstM, mm.dste, mm.dstm);
      end
      n_chk++; if (M_valE !== mm.vale || M_valA !== mm.vala) begin
        n_fail++; $display("FAIL rnd_M_val c%0d: got %h/%h expected %h/%h", c, M_valE, M_valA, mm.vale, mm.vala);
      end
      for (int i = 0; i < 15; i++) begin
        n_chk++; if (rv[i] !== mr[i]) begin n_fail++; $display("FAIL rnd_reg%0d c%0d: got %h expected %h", i, c, rv[i], mr[i]); end
      end
    end
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #12 rst_n = 1'b1;
    @(negedge clk);
    test_forwarding();
    test_reset();
    test_load_use();
    test_mispredict();
    test_overflow_cmov();
    test_ret_exception();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
